// File: rtl/instr_mem_fetch_pkg.sv
// Shared definitions for the instruction fetch path: word width, NOP encoding,
// opcode field placement and the response-register state type.
package instr_mem_fetch_pkg;

  localparam int unsigned INSTR_W_DEF = 32'd19;
  localparam logic [18:0] NOP_ENC     = 19'h0_0000;

  // Opcode occupies the top five bits of the 19-bit instruction word.
  localparam int unsigned OPC_MSB = 32'd18;
  localparam int unsigned OPC_LSB = 32'd14;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_e;

  function automatic logic [4:0] opcode_of(input logic [18:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x INSTR_W single-write-port RAM with a registered read port.
// Contents are not reset; only the read register is.
module instr_mem_array #(
  parameter int INSTR_W = 19,
  parameter int DEPTH   = 256,
  parameter int AW      = 8
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_r [DEPTH];
  logic [INSTR_W-1:0] rdata_r;

  // Storage write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; holds its value when no read is requested
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {INSTR_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with valid/ready fetch, one-entry response register,
// run-time program load, flush and saturating out-of-range fault counter.
module instr_mem_fetch
  import instr_mem_fetch_pkg::*;
#(
  parameter int                 INSTR_W  = INSTR_W_DEF,
  parameter int                 DEPTH    = 256,
  parameter int                 ADDR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_ENC),
  parameter int                 CNT_W    = 8
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [INSTR_W-1:0] resp_instr,
  output logic               resp_fault,
  input  logic               flush,
  input  logic               load_valid,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic [CNT_W-1:0]   fault_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_state_e        state_r, state_nxt_s;
  logic               resp_fault_r;
  logic [CNT_W-1:0]   fault_count_r;
  logic [INSTR_W-1:0] rdata_s;
  logic               req_ready_s, accept_s, req_in_range_s, ld_in_range_s;
  logic               rd_en_s, wr_en_s, deliver_fault_s;

  // Handshake, array enables and response-register next state
  always_comb begin
    req_ready_s     = 1'b0;
    accept_s        = 1'b0;
    rd_en_s         = 1'b0;
    wr_en_s         = 1'b0;
    deliver_fault_s = 1'b0;
    state_nxt_s     = state_r;
    req_in_range_s  = (req_addr < ADDR_W'(DEPTH));
    ld_in_range_s   = (load_addr < ADDR_W'(DEPTH));

    if (load_valid) begin
      req_ready_s = 1'b0;
    end else begin
      req_ready_s = (state_r == RESP_EMPTY) || resp_ready;
    end
    accept_s = req_valid && req_ready_s;
    rd_en_s  = accept_s && req_in_range_s;
    // Gating with rst_n keeps a load coinciding with reset from landing.
    wr_en_s  = load_valid && ld_in_range_s && rst_n;
    // A response killed by flush is never treated as delivered.
    deliver_fault_s = (state_r == RESP_FULL) && resp_ready && !flush && resp_fault_r;

    case (state_r)
      RESP_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = RESP_FULL;
        end else begin
          state_nxt_s = RESP_EMPTY;
        end
      end
      RESP_FULL: begin
        if (accept_s) begin
          state_nxt_s = RESP_FULL;
        end else if (flush || resp_ready) begin
          state_nxt_s = RESP_EMPTY;
        end else begin
          state_nxt_s = RESP_FULL;
        end
      end
      default: state_nxt_s = RESP_EMPTY;
    endcase
  end

  // Response state and fault flag registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RESP_EMPTY;
      resp_fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        resp_fault_r <= !req_in_range_s;
      end
    end
  end

  // Saturating count of delivered faulting fetches
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fault_count_r <= {CNT_W{1'b0}};
    end else if (deliver_fault_s && (fault_count_r != {CNT_W{1'b1}})) begin
      fault_count_r <= fault_count_r + CNT_W'(1);
    end
  end

  instr_mem_array #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_array (
    .clock (clock),
    .rst_n (rst_n),
    .we    (wr_en_s),
    .waddr (load_addr[AW-1:0]),
    .wdata (load_data),
    .re    (rd_en_s),
    .raddr (req_addr[AW-1:0]),
    .rdata (rdata_s)
  );

  // The array is not read on a fault, so its stale word is masked here.
  assign resp_instr  = resp_fault_r ? NOP_WORD : rdata_s;
  assign resp_fault  = resp_fault_r;
  assign resp_valid  = (state_r == RESP_FULL);
  assign req_ready   = req_ready_s;
  assign fault_count = fault_count_r;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch with a scoreboard queue of expected
// responses and a reference copy of the program memory.
module tb_instr_mem_fetch;
  import instr_mem_fetch_pkg::*;

  localparam int INSTR_W = 19;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 8;

  logic               clock, rst_n;
  logic               req_valid, req_ready, resp_valid, resp_ready;
  logic               resp_fault, flush, load_valid;
  logic [ADDR_W-1:0]  req_addr, load_addr;
  logic [INSTR_W-1:0] resp_instr, load_data;
  logic [CNT_W-1:0]   fault_count;

  instr_mem_fetch #(
    .INSTR_W (INSTR_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W),
    .NOP_WORD (19'h0_0000), .CNT_W (CNT_W)
  ) dut (
    .clock (clock), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
    .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_instr (resp_instr), .resp_fault (resp_fault),
    .flush (flush), .load_valid (load_valid), .load_addr (load_addr),
    .load_data (load_data), .fault_count (fault_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int fc_exp = 0;
  logic [INSTR_W-1:0] mem_m [DEPTH];
  logic [INSTR_W:0]   sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] ra, input logic rr,
                       input logic fl, input logic lv, input logic [31:0] la,
                       input logic [18:0] ld);
    req_valid = rv; req_addr = ra; resp_ready = rr;
    flush = fl; load_valid = lv; load_addr = la; load_data = ld;
  endtask

  // One clock: model the handshake mid-cycle, then check state after the edge.
  task automatic step();
    logic             exp_ready;
    logic [INSTR_W:0] e;
    #4;
    if (rst_n) begin
      exp_ready = !load_valid && ((sb_q.size() == 0) || resp_ready);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if ((sb_q.size() != 0) && (flush || resp_ready)) begin
        e = sb_q.pop_front();
        if (!flush) begin
          chk("resp_instr", 32'(resp_instr), 32'(e[INSTR_W-1:0]));
          chk("resp_fault", 32'(resp_fault), 32'(e[INSTR_W]));
          if (e[INSTR_W] && (fc_exp < 255)) fc_exp++;
        end
      end
      if (load_valid && (load_addr < DEPTH)) mem_m[load_addr[7:0]] = load_data;
      if (req_valid && exp_ready) begin
        if (req_addr < DEPTH) sb_q.push_back({1'b0, mem_m[req_addr[7:0]]});
        else                  sb_q.push_back({1'b1, 19'h0_0000});
      end
    end else begin
      sb_q.delete();
      fc_exp = 0;
    end
    @(posedge clock);
    #1;
    if (rst_n) begin
      chk("resp_valid", 32'(resp_valid), 32'(sb_q.size() != 0));
      chk("fault_count", 32'(fault_count), 32'(fc_exp));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 19'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_instr", 32'(resp_instr), 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_fault_count", 32'(fault_count), 32'd0);
    rst_n = 1'b1;

    // Program load; a fetch offered during a load must not be accepted
    drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, 19'h40864); step();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd1, 19'h40A66); step();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd255, 19'h7FFFF); step();

    // Back-to-back fetches
    drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b1, 32'd255, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step(); step();

    // Stall with response held
    drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0, 19'h0);
    repeat (3) begin
      step();
      chk("stall_instr", 32'(resp_instr), 32'h40864);
    end
    drive(1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step(); step();

    // Faulting fetches at 300 and at the first illegal address
    drive(1'b1, 32'd300, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b1, 32'd256, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    chk("fault_count_1", 32'(fault_count), 32'd1);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();

    // Load and fetch in the same cycle, then read-after-write
    drive(1'b1, 32'd5, 1'b1, 1'b0, 1'b1, 32'd5, 19'h12345); step();
    drive(1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();

    // Flush of a held response with a new fetch accepted alongside
    drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b1, 32'd1, 1'b1, 1'b1, 1'b0, 32'd0, 19'h0); step();
    chk("flush_instr", 32'(resp_instr), 32'h40A66);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();

    // A flushed faulting response is not counted
    drive(1'b1, 32'd300, 1'b0, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 19'h0); step();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();

    // Flush and load together; out-of-range load is dropped
    drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b1, 32'd6, 1'b1, 1'b1, 1'b1, 32'd6, 19'h2AAAA); step();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd300, 19'h55555); step();
    drive(1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();

    // Counter saturation
    drive(1'b1, 32'd300, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0);
    repeat (300) step();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    chk("fault_sat", 32'(fault_count), 32'd255);

    // Reset while FULL, with a load offered during reset
    drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 19'h0); step();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, 19'h11111);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_fault_count", 32'(fault_count), 32'd0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();
    chk("post_rst_instr", 32'(resp_instr), 32'h40864);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 19'h0); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
Parametrised, synchronous-read instruction memory with a valid/ready fetch interface, a run-time program-load port and out-of-range fault reporting. It sits between the PC/fetch stage and decode. It replaces the fixed, combinational-read, hard-coded-contents store. A one-entry response register supports fetch-stage stalls, and a flush input drops a stale fetch on a taken branch or jump.

Parameters:
INSTR_W, 19, instruction word width in bits
DEPTH, 256, number of instruction words; legal word addresses 0..DEPTH-1
ADDR_W, 32, width of fetch/load address (word-addressed, PC units)
NOP_WORD, 0, instruction returned on a faulting fetch
CNT_W, 8, width of saturating fault counter

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request present
req_ready  out  1  fetch request accepted this cycle when high with req_valid
req_addr  in  ADDR_W  fetch word address
resp_valid  out  1  resp_instr/resp_fault hold a valid fetch result
resp_ready  in  1  consumer takes the response this cycle
resp_instr  out  INSTR_W  fetched instruction
resp_fault  out  1  fetch address was >= DEPTH
flush  in  1  discard the held or in-flight response
load_valid  in  1  write load_data to load_addr this cycle
load_addr  in  ADDR_W  program-load word address
load_data  in  INSTR_W  program-load data
fault_count  out  CNT_W  saturating count of faulting fetches delivered

Behaviour:
- Reset (rst_n low, asynchronous): resp_valid=0, resp_instr=0, resp_fault=0, fault_count=0. Memory array is not reset; contents persist across reset.
- Response register states: EMPTY (resp_valid=0), FULL (resp_valid=1).
- req_ready = !load_valid && (EMPTY || resp_ready). This is combinational from state, load_valid and resp_ready. It does not depend on req_valid.
- Accepted request (req_valid && req_ready) at edge N: the response appears at edge N+1 with resp_valid=1. Latency is 1 cycle. Back-to-back accepts give one response per cycle.
- FULL && !resp_ready: resp_instr/resp_fault hold stable and req_ready=0.
- FULL && resp_ready && no accept: go to EMPTY.
- Fault: req_addr >= DEPTH gives resp_fault=1 and resp_instr=NOP_WORD. The array is not read. fault_count increments on delivery (resp_valid && resp_ready && resp_fault) and saturates at 2^CNT_W-1.
- Load: when load_valid and load_addr < DEPTH, the word is written at the edge. Out-of-range load is silently ignored. Load has priority: no fetch is accepted in a load cycle.
- A fetch accepted the cycle after a write to the same address returns the new data (no read-before-write hazard across cycles).
- flush: forces resp_valid=0 at the next edge, discarding any held response. If a request is also accepted in the flush cycle, that new request is kept and its response is valid at the next edge (flush kills only the old result). A flushed response never counts toward fault_count.
- Simultaneous flush and load: both take effect; load writes, and no fetch is accepted.
- rst_n asserted mid-operation: the pending response is lost and no write occurs in that cycle.
- resp_instr updates only on an accepted fetch. In EMPTY it retains its last value (don't-care to consumers).

Decomposition:
- Shared package: INSTR_W default, NOP encoding, opcode field constants used by decode and the bench program images.
- One sub-module: instr_mem_array, a DEPTH x INSTR_W single-write, synchronous-read RAM with write port and registered read.
- Handshake, fault logic and counter stay in the top module.

Test Plan:
- Reset, load addr0=0x40864 and addr1=0x40A66, then fetch 0 then 1 back-to-back with resp_ready=1 -> resp_valid on the following edges with 0x40864, then 0x40A66, resp_fault=0.
- Stall: fetch addr0, hold resp_ready=0 for 3 cycles -> req_ready=0, resp_instr stable at 0x40864; raise resp_ready -> accepted and next fetch proceeds.
- Fetch addr 300 (DEPTH=256) -> resp_fault=1, resp_instr=0, fault_count 0->1 on delivery. Issue 300 faults -> fault_count saturates at 255.
- Load and fetch in the same cycle -> req_ready=0; write addr5=0x12345, fetch 5 next cycle -> returns 0x12345.
- Flush with FULL and an accepted fetch of addr1 in the same cycle -> old response dropped; next edge resp_valid=1, resp_instr=0x40A66.
- Assert rst_n low while FULL -> resp_valid=0 immediately. Memory contents remain: a fetch of addr0 after reset returns 0x40864.
